kmer_window_shifter: RTL and testbench
======================================

# kmer_window_shifter

Parametrised successor to the team's fixed 512-bit, 2-bit-per-step nucleotide shift register. It consumes a stream of packed-nucleotide words with valid/ready and emits one K-mer window per accepted output beat, advancing STEP symbols per beat. Windows are continuous across word boundaries, and each carries its symbol position and an end-of-sequence flag. It sits between the database word fetcher and the seed-lookup/hash stage of the BLAST pipeline.

## Interface
- DATA_W, 512: input word width, bits; must be a multiple of SYM_W.
- SYM_W, 2: bits per symbol (2 = nucleotide encoding).
- K, 11: window length in symbols; 2 ≤ K ≤ DATA_W/SYM_W.
- STEP, 1: symbols advanced per output beat; 1 ≤ STEP ≤ K.
- POS_W, 32: width of the position counter.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- in_data  in  DATA_W  packed symbols; symbol 0 (oldest) is bits [SYM_W-1:0].
- in_valid  in  1  in_data valid.
- in_last  in  1  word is the final word of the sequence.
- in_ready  out  1  word accepted when in_valid & in_ready.
- out_window  out  K*SYM_W  current window; symbol 0 is at the LSBs.
- out_pos  out  POS_W  sequence index of window symbol 0.
- out_last  out  1  final window of the sequence.
- out_valid  out  1  window valid.
- out_ready  in  1  window consumed when out_valid & out_ready.
- out_window_rc  out  K*SYM_W  reverse complement of out_window; present only with KMER_REVCOMP_EN.

## Operation
- SYMS = DATA_W/SYM_W. Buffer capacity CAP = SYMS+K-1 symbols. Occupancy counter cnt ranges 0..CAP.
- out_fire = out_valid & out_ready. in_fire = in_valid & in_ready.
- out_valid = (cnt ≥ K) while rst is high. out_window = buffer symbols [0..K-1], driven directly from the buffer register.
- cnt_after = out_fire ? cnt-STEP : cnt. in_ready = rst & !last_pend & (cnt_after ≤ K-1). in_ready has a combinational path from out_ready.
- Per cycle, in priority order:
  - Shift: on out_fire, discard STEP symbols from the bottom.
  - Load: on in_fire, write in_data at symbol offset cnt_after.
  - Occupancy update: cnt ← cnt_after + (in_fire ? SYMS : 0).
  - Load and shift in the same cycle are both applied; no bubble.
- out_pos: cleared at sequence start; incremented by STEP on each out_fire. Wraps modulo 2^POS_W.
- last_pend: set on in_fire with in_last. out_last = last_pend & (cnt-STEP < K) & out_valid.
- Final window fire (out_fire & out_last): cnt ← 0, out_pos ← 0, last_pend ← 0. Trailing symbols are discarded.
- Short sequence: if last_pend and cnt < K (sequence shorter than K), no window is emitted. Next cycle cnt ← 0 and last_pend ← 0.
- A new sequence cannot load in the cycle its predecessor's final window fires (last_pend blocks in_ready). This costs exactly one bubble between sequences.
- Unused buffer symbols above cnt are don't-care and never reach out_window.

## Timing
- Reset (rst=0 at edge): cnt=0, last_pend=0, out_pos=0. Outputs: out_valid=0, out_last=0, in_ready=0 while rst=0. out_window and out_window_rc are don't-care.
- Reset mid-sequence drops all buffered data and any pending last.
- First cycle after reset release: in_ready=1.
- Latency: a word accepted at edge n presents its first window (if cnt ≥ K) after edge n; out_valid=1 in cycle n+1.
- Streaming: with out_ready held high and the source never starving, one window is produced every cycle across word boundaries.
- Backpressure: while out_valid=1 and out_ready=0, out_window, out_pos and out_last are held stable.

## Configuration
- KMER_REVCOMP_EN defined:
  - Adds out_window_rc. Symbol i of rc = bitwise NOT of out_window symbol K-1-i.
  - Purely combinational from the buffer, so zero added latency.
  - Legal only with SYM_W=2; elaboration error otherwise.
- Not defined: port and logic are absent.

## Test plan
- Defaults, one word, in_last=1, out_ready=1:
  - 246 windows, out_pos 0..245, out_last only at pos 245.
  - in_ready low until the cycle after the final window, then 1.
- Two consecutive words, second word in_last=1, out_ready=1:
  - 502 windows on consecutive cycles, no gap at the boundary.
  - Second word accepted in the same cycle as the window at pos 245.
  - Window at pos 250 = word0 symbols 250..255 followed by word1 symbols 0..4.
- Backpressure: out_ready=0 for 5 cycles at pos 100:
  - out_window and out_pos=100 held stable.
  - Resuming out_ready=1 gives pos 101 next.
- rst=0 for one cycle at pos 50 of a two-word sequence:
  - Next cycle out_valid=0, out_pos=0, in_ready=1.
  - The following word restarts at pos 0.
- STEP=4, K=11, one last word: 62 windows at pos 0,4,…,244; out_last at pos 244.
- KMER_REVCOMP_EN, window symbols 0,1,2,3,0,…:
  - out_window_rc = complements in reverse order.
  - Check: all-00 window gives all-11 rc.

Source files
------------

// File: rtl/kmer_window_shifter.sv
// Sliding K-mer window over a stream of packed-symbol words, STEP symbols per output beat.
// Define KMER_REVCOMP_EN to add the out_window_rc reverse-complement output (SYM_W=2 only).
module kmer_window_shifter #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned SYM_W  = 2,
  parameter int unsigned K      = 11,
  parameter int unsigned STEP   = 1,
  parameter int unsigned POS_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [K*SYM_W-1:0] out_window,
  output logic [POS_W-1:0]   out_pos,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready
`ifdef KMER_REVCOMP_EN
  ,
  output logic [K*SYM_W-1:0] out_window_rc
`endif
);

  localparam int unsigned SYMS  = DATA_W / SYM_W;
  localparam int unsigned CAP   = SYMS + K - 1;
  localparam int unsigned BUF_W = CAP * SYM_W;
  localparam int unsigned CNT_W = $clog2(CAP + 1);

  localparam logic [CNT_W-1:0] KC    = CNT_W'(K);
  localparam logic [CNT_W-1:0] STEPC = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] SYMSC = CNT_W'(SYMS);

  if (DATA_W % SYM_W != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of SYM_W");
  end
  if (K < 2 || K > SYMS) begin : g_bad_k
    $error("K must satisfy 2 <= K <= DATA_W/SYM_W");
  end
  if (STEP < 1 || STEP > K) begin : g_bad_step
    $error("STEP must satisfy 1 <= STEP <= K");
  end

  logic [BUF_W-1:0] sym_buf_q, sym_buf_d;
  logic [BUF_W-1:0] shifted, low_mask;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_after;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             last_pend_q, last_pend_d;
  logic             out_fire, in_fire, final_fire, short_seq;
  logic [31:0]      wr_off;

  assign out_valid  = rst & (cnt_q >= KC);
  assign out_fire   = out_valid & out_ready;
  assign cnt_after  = out_fire ? cnt_q - STEPC : cnt_q;
  assign in_ready   = rst & ~last_pend_q & (cnt_after < KC);
  assign in_fire    = in_valid & in_ready;
  // K+STEP can equal 2**CNT_W, so compare at 32 bits.
  assign out_last   = last_pend_q & out_valid & (32'(cnt_q) < K + STEP);
  assign final_fire = out_fire & out_last;
  assign short_seq  = last_pend_q & (cnt_q < KC);

  assign out_window = sym_buf_q[K*SYM_W-1:0];
  assign out_pos    = pos_q;

  always_comb begin
    shifted   = out_fire ? (sym_buf_q >> (STEP * SYM_W)) : sym_buf_q;
    wr_off    = 32'(cnt_after) * SYM_W;
    low_mask  = ~({BUF_W{1'b1}} << wr_off);
    sym_buf_d = shifted;
    // Incoming word lands directly above the surviving symbols.
    if (in_fire) sym_buf_d = (shifted & low_mask) | (BUF_W'(in_data) << wr_off);
  end

  always_comb begin
    cnt_d       = cnt_after + (in_fire ? SYMSC : '0);
    pos_d       = out_fire ? pos_q + POS_W'(STEP) : pos_q;
    last_pend_d = last_pend_q | (in_fire & in_last);
    if (final_fire || short_seq) begin
      cnt_d       = '0;
      pos_d       = '0;
      last_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      pos_q       <= '0;
      last_pend_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      last_pend_q <= last_pend_d;
    end
  end

  // Contents above cnt are don't-care, so the data path carries no reset.
  always_ff @(posedge clk) begin
    sym_buf_q <= sym_buf_d;
  end

`ifdef KMER_REVCOMP_EN
  if (SYM_W != 2) begin : g_bad_rc
    $error("KMER_REVCOMP_EN requires SYM_W == 2");
  end
  for (genvar i = 0; i < K; i++) begin : g_rc
    assign out_window_rc[i*SYM_W +: SYM_W] = ~out_window[(K-1-i)*SYM_W +: SYM_W];
  end
`endif

endmodule

// File: tb/tb_kmer_window_shifter.sv
// Self-checking bench for kmer_window_shifter: default instance plus a STEP=4 instance,
// checked against a symbol-sequence reference model.
module tb_kmer_window_shifter;
  localparam int DATA_W = 512;
  localparam int SYM_W  = 2;
  localparam int K      = 11;
  localparam int STEP   = 1;
  localparam int POS_W  = 32;
  localparam int SYMS   = DATA_W / SYM_W;
  localparam int KW     = K * SYM_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [KW-1:0]     out_window;
  logic [POS_W-1:0]  out_pos;
  logic              out_last, out_valid;
  logic              out_ready = 1'b0;

  logic [DATA_W-1:0] s4_in_data = '0;
  logic              s4_in_valid = 1'b0, s4_in_last = 1'b0, s4_in_ready;
  logic [KW-1:0]     s4_out_window;
  logic [POS_W-1:0]  s4_out_pos;
  logic              s4_out_last, s4_out_valid;
  logic              s4_out_ready = 1'b0;
`ifdef KMER_REVCOMP_EN
  logic [KW-1:0]     out_window_rc, s4_out_window_rc;
`endif

  kmer_window_shifter #(
    .DATA_W(DATA_W), .SYM_W(SYM_W), .K(K), .STEP(STEP), .POS_W(POS_W)
  ) u_dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_window(out_window), .out_pos(out_pos), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef KMER_REVCOMP_EN
    , .out_window_rc(out_window_rc)
`endif
  );

  kmer_window_shifter #(
    .DATA_W(DATA_W), .SYM_W(SYM_W), .K(K), .STEP(4), .POS_W(POS_W)
  ) u_dut_s4 (
    .clk(clk), .rst(rst),
    .in_data(s4_in_data), .in_valid(s4_in_valid), .in_last(s4_in_last),
    .in_ready(s4_in_ready),
    .out_window(s4_out_window), .out_pos(s4_out_pos), .out_last(s4_out_last),
    .out_valid(s4_out_valid), .out_ready(s4_out_ready)
`ifdef KMER_REVCOMP_EN
    , .out_window_rc(s4_out_window_rc)
`endif
  );

  int n_pass = 0, n_fail = 0, n_total = 0;
  logic [DATA_W-1:0] words[$];
  int nwin;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // Reference: symbol j of the sequence is symbol j%SYMS of word j/SYMS.
  function automatic logic [1:0] sym_at(input int j);
    logic [DATA_W-1:0] w;
    w = words[j / SYMS];
    return w[(j % SYMS)*SYM_W +: SYM_W];
  endfunction

  function automatic logic [KW-1:0] exp_win(input int p);
    logic [KW-1:0] w;
    for (int i = 0; i < K; i++) w[i*SYM_W +: SYM_W] = sym_at(p + i);
    return w;
  endfunction

  function automatic logic [KW-1:0] rev_comp(input logic [KW-1:0] w);
    logic [KW-1:0] r;
    for (int i = 0; i < K; i++) r[i*SYM_W +: SYM_W] = ~w[(K-1-i)*SYM_W +: SYM_W];
    return r;
  endfunction

  // pat 0 = random words, 1 = all-zero words.
  task automatic run_seq(input int nw, input int rdy_pct, input int stall_pos,
                         input int abort_pos, input int pat);
    int  p = 0, wi = 0, total, budget = 20000, stall_left = 5, loaded;
    bit  done = 0, presenting = 0, ofire, ifire, last_loaded, exp_valid, exp_ready, exp_last;
    words.delete();
    for (int i = 0; i < nw; i++) words.push_back(pat == 1 ? '0 : rand_word());
    total = nw * SYMS;
    nwin  = 0;
    while (!done && budget > 0) begin
      budget--;
      @(negedge clk);
      if (abort_pos >= 0 && p == abort_pos) begin
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_out_pos", out_pos, 0);
        chk("abort_in_ready", in_ready, 1'b1);
        return;
      end
      if (!presenting && wi < nw) presenting = (rdy_pct >= 100) || ($urandom_range(99) < 70);
      in_valid = presenting;
      in_last  = presenting && (wi == nw - 1);
      if (presenting) in_data = words[wi];
      if (stall_pos >= 0 && p == stall_pos && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = (rdy_pct >= 100) || ($urandom_range(99) < rdy_pct);
      end
      #1;
      loaded      = wi * SYMS;
      last_loaded = (wi == nw);
      exp_valid   = (loaded - p >= K);
      exp_last    = exp_valid && last_loaded && (p + STEP + K > total);
      ofire       = exp_valid && out_ready;
      exp_ready   = !last_loaded && (loaded - p - (ofire ? STEP : 0) <= K - 1);
      chk("out_valid", out_valid, exp_valid);
      chk("in_ready", in_ready, exp_ready);
      if (exp_valid) begin
        chk("out_pos", out_pos, p);
        chk("out_window", out_window, exp_win(p));
        chk("out_last", out_last, exp_last);
`ifdef KMER_REVCOMP_EN
        chk("out_window_rc", out_window_rc, rev_comp(exp_win(p)));
        if (pat == 1) chk("rc_all_ones", out_window_rc, {KW{1'b1}});
`endif
      end
      ifire = presenting && exp_ready;
      @(posedge clk);
      if (ifire) begin
        wi++;
        presenting = 0;
      end
      if (ofire) begin
        nwin++;
        if (exp_last) done = 1;
        else p += STEP;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("seq_done", done, 1'b1);
  endtask

  initial begin
    int p, n, budget;
    bit done, fire, taken, elast;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    rst = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_out_pos", out_pos, 0);
    chk("rel_out_valid", out_valid, 1'b0);

    run_seq(1, 100, -1, -1, 0);
    chk("one_word_count", nwin, 246);
    run_seq(2, 100, -1, -1, 0);
    chk("two_word_count", nwin, 502);
    run_seq(2, 100, 100, -1, 0);
    chk("stall_count", nwin, 502);
    run_seq(2, 100, -1, 50, 0);
    run_seq(1, 100, -1, -1, 0);
    chk("after_abort_count", nwin, 246);
    run_seq(1, 100, -1, -1, 1);
    chk("zero_word_count", nwin, 246);
    for (int r = 0; r < 4; r++) begin
      n = 1 + $urandom_range(1);
      run_seq(n, 60, -1, -1, 0);
      chk("random_count", nwin, (n * SYMS - K) / STEP + 1);
    end

    // STEP=4 instance: one final word.
    words.delete();
    words.push_back(rand_word());
    p = 0; n = 0; budget = 1000; done = 0; taken = 0;
    while (!done && budget > 0) begin
      budget--;
      @(negedge clk);
      s4_in_valid  = !taken;
      s4_in_last   = !taken;
      s4_in_data   = words[0];
      s4_out_ready = 1'b1;
      #1;
      fire = s4_out_valid;
      elast = (p + 4 + K > SYMS);
      if (s4_out_valid) begin
        chk("s4_out_pos", s4_out_pos, p);
        chk("s4_out_window", s4_out_window, exp_win(p));
        chk("s4_out_last", s4_out_last, elast);
      end
      if (s4_in_valid && s4_in_ready) taken = 1;
      @(posedge clk);
      if (fire) begin
        n++;
        if (elast) done = 1;
        else p += 4;
      end
    end
    @(negedge clk);
    s4_in_valid = 1'b0;
    s4_in_last  = 1'b0;
    chk("s4_done", done, 1'b1);
    chk("s4_count", n, 62);
    chk("s4_final_pos", p, 244);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
